// File: rtl/mux8_rr_sched_pkg.sv
// -----------------------------------------------------------------------------
// mux8_sched_pkg
//   Shared types and helpers for the 8-requester round-robin mux scheduler.
//   NUM_REQ / SEL_W : requester count and select width of the 8:1 mux.
//   sched_state_e   : scheduler FSM states.
//   pick_t / rr_pick: rotating first-set-bit search starting at a pointer.
//   onehot8         : index to one-hot grant vector.
// -----------------------------------------------------------------------------
package mux8_sched_pkg;

   localparam int unsigned NUM_REQ = 8;
   localparam int unsigned SEL_W   = 3;

   typedef enum logic {
      IDLE,
      GRANT
   } sched_state_e;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } pick_t;

   // First set bit of req at or above ptr, wrapping. Scanning from the far end
   // lets the nearest candidate overwrite the result without an early exit.
   function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                     input logic [SEL_W-1:0]   ptr);
      pick_t            res;
      logic [SEL_W-1:0] cand;
      res = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = ptr + SEL_W'(i);
         if (req[cand]) begin
            res.found = 1'b1;
            res.idx   = cand;
         end
      end
      return res;
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux8_rr_sched_if.sv
// -----------------------------------------------------------------------------
// mux8_rr_sched_if
//   Requester/scheduler bus for mux8_rr_sched.
//   req_i, mask_i : requester side -> scheduler (valid per requester, enables)
//   gnt_o, sel_o  : one-hot grant and mux select
//   vld_o, src_o  : beat-valid and source id aligned with the registered mux output
//   busy_o        : a grant is active
//   master modport = requester side, slave modport = scheduler.
// -----------------------------------------------------------------------------
interface mux8_rr_sched_if;
   import mux8_sched_pkg::*;

   logic [NUM_REQ-1:0] req_i;
   logic [NUM_REQ-1:0] mask_i;
   logic [NUM_REQ-1:0] gnt_o;
   logic [SEL_W-1:0]   sel_o;
   logic               vld_o;
   logic [SEL_W-1:0]   src_o;
   logic               busy_o;

   modport master (
      output req_i,
      output mask_i,
      input  gnt_o,
      input  sel_o,
      input  vld_o,
      input  src_o,
      input  busy_o
   );

   modport slave (
      input  req_i,
      input  mask_i,
      output gnt_o,
      output sel_o,
      output vld_o,
      output src_o,
      output busy_o
   );

endinterface

// File: rtl/mux8_16.sv
// -----------------------------------------------------------------------------
// mux8_16
//   Registered 8:1 mux, 16-bit data. y_o takes the selected input at each
//   rising edge, so y_o in cycle N+1 reflects sel_i in cycle N.
//   clk_i, rst_i : clock, asynchronous active-high reset (y_o cleared)
//   a_i..h_i     : data inputs 0..7
//   sel_i        : input select
//   y_o          : registered output
// -----------------------------------------------------------------------------
module mux8_16 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic [15:0] c_i,
   input  logic [15:0] d_i,
   input  logic [15:0] e_i,
   input  logic [15:0] f_i,
   input  logic [15:0] g_i,
   input  logic [15:0] h_i,
   input  logic [2:0]  sel_i,
   output logic [15:0] y_o
);

   logic [15:0] y_d;
   logic [15:0] y_q;

   always_comb begin
      y_d = a_i;
      case (sel_i)
         3'd0:    y_d = a_i;
         3'd1:    y_d = b_i;
         3'd2:    y_d = c_i;
         3'd3:    y_d = d_i;
         3'd4:    y_d = e_i;
         3'd5:    y_d = f_i;
         3'd6:    y_d = g_i;
         default: y_d = h_i;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         y_q <= '0;
      end else begin
         y_q <= y_d;
      end
   end

   assign y_o = y_q;

endmodule

// File: rtl/mux8_rr_sched_rr_prio_enc8.sv
// -----------------------------------------------------------------------------
// rr_prio_enc8
//   Purely combinational rotating priority encoder.
//   req_i   : candidate vector
//   ptr_i   : highest-priority position; search goes upward with wrap
//   found_o : any candidate set
//   idx_o   : index of the winner (0 when none found)
// -----------------------------------------------------------------------------
module rr_prio_enc8
   import mux8_sched_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [SEL_W-1:0]   ptr_i,
   output logic               found_o,
   output logic [SEL_W-1:0]   idx_o
);

   pick_t pick;

   always_comb begin
      pick    = rr_pick(req_i, ptr_i);
      found_o = pick.found;
      idx_o   = pick.idx;
   end

endmodule

// File: rtl/mux8_rr_sched.sv
// -----------------------------------------------------------------------------
// mux8_rr_sched
//   Round-robin scheduler sharing the registered 8:1 mux among 8 requesters.
//   Grants one requester for up to BurstLen beats, then rearbitrates in the
//   same cycle starting just above the previous owner. Tags the mux output
//   with a valid bit and the source index.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus (slave)  : req_i/mask_i in; gnt_o/sel_o/vld_o/src_o/busy_o out,
//                  all outputs registered
// -----------------------------------------------------------------------------
module mux8_rr_sched
   import mux8_sched_pkg::*;
#(
   parameter int unsigned NumReq   = 8,
   parameter int unsigned BurstLen = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   mux8_rr_sched_if.slave bus
);

   localparam int unsigned CntW = $clog2(BurstLen + 1);

   if (NumReq != NUM_REQ) begin : g_num_req_chk
      $error("mux8_rr_sched: NumReq must be 8");
   end
   if (BurstLen < 1 || BurstLen > 16) begin : g_burst_len_chk
      $error("mux8_rr_sched: BurstLen must be 1..16");
   end

   sched_state_e       state_q, state_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               vld_q, vld_d;
   logic [SEL_W-1:0]   src_q, src_d;
   logic               busy_q, busy_d;

   logic [NUM_REQ-1:0] elig;
   logic               beat;
   logic [CntW-1:0]    cnt_inc;
   logic               keep;
   logic [SEL_W-1:0]   arb_ptr;
   logic               arb_found;
   logic [SEL_W-1:0]   arb_idx;

   assign elig    = bus.req_i & bus.mask_i;
   // sel_q is the owner's index while in GRANT.
   assign beat    = (state_q == GRANT) && elig[sel_q];
   assign cnt_inc = cnt_q + CntW'(1);
   assign keep    = beat && (cnt_inc < CntW'(BurstLen));
   // From IDLE search from the stored pointer; at burst end search from owner+1
   // so the outgoing owner is considered last.
   assign arb_ptr = (state_q == IDLE) ? ptr_q : sel_q + SEL_W'(1);

   rr_prio_enc8 u_prio_enc (
      .req_i   (elig),
      .ptr_i   (arb_ptr),
      .found_o (arb_found),
      .idx_o   (arb_idx)
   );

   // State register and all output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         sel_q   <= '0;
         vld_q   <= 1'b0;
         src_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         vld_q   <= vld_d;
         src_q   <= src_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (arb_found) state_d = GRANT;
         end
         GRANT: begin
            if (!keep && !arb_found) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next values.
   always_comb begin
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      gnt_d  = gnt_q;
      sel_d  = sel_q;
      busy_d = busy_q;
      // The mux captures sel_q this cycle, so tag it one cycle later.
      vld_d  = beat;
      src_d  = sel_q;
      case (state_q)
         IDLE: begin
            if (arb_found) begin
               gnt_d  = onehot8(arb_idx);
               sel_d  = arb_idx;
               cnt_d  = '0;
               busy_d = 1'b1;
            end else begin
               gnt_d  = '0;
               busy_d = 1'b0;
            end
         end
         GRANT: begin
            if (keep) begin
               cnt_d = cnt_inc;
            end else begin
               ptr_d = sel_q + SEL_W'(1);
               cnt_d = '0;
               if (arb_found) begin
                  gnt_d  = onehot8(arb_idx);
                  sel_d  = arb_idx;
                  busy_d = 1'b1;
               end else begin
                  // sel holds its last value to avoid toggling the mux.
                  gnt_d  = '0;
                  busy_d = 1'b0;
               end
            end
         end
         default: begin
            gnt_d  = '0;
            busy_d = 1'b0;
         end
      endcase
   end

   assign bus.gnt_o  = gnt_q;
   assign bus.sel_o  = sel_q;
   assign bus.vld_o  = vld_q;
   assign bus.src_o  = src_q;
   assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
module tb_mux8_rr_sched;

   logic        clk;
   logic        rst;
   logic [15:0] din [8];
   logic [15:0] y;

   int n_pass  = 0;
   int n_total = 0;

   mux8_rr_sched_if bus4 ();
   mux8_rr_sched_if bus1 ();

   mux8_rr_sched #(.NumReq(8), .BurstLen(4)) u_dut4 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus4)
   );

   mux8_rr_sched #(.NumReq(8), .BurstLen(1)) u_dut1 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus1)
   );

   mux8_16 u_mux (
      .clk_i (clk),
      .rst_i (rst),
      .a_i   (din[0]),
      .b_i   (din[1]),
      .c_i   (din[2]),
      .d_i   (din[3]),
      .e_i   (din[4]),
      .f_i   (din[5]),
      .g_i   (din[6]),
      .h_i   (din[7]),
      .sel_i (bus4.sel_o),
      .y_o   (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   initial begin
      int          exp_sel;
      int          prev_sel;
      logic [7:0]  exp_gnt;

      for (int k = 0; k < 8; k++) din[k] = 16'hA000 + 16'(k * 273);
      rst         = 1'b1;
      bus4.req_i  = 8'h00;
      bus4.mask_i = 8'hFF;
      bus1.req_i  = 8'h00;
      bus1.mask_i = 8'hFF;

      // Reset state
      tick();
      tick();
      chk("rst_gnt",  32'(bus4.gnt_o),  32'h0);
      chk("rst_sel",  32'(bus4.sel_o),  32'h0);
      chk("rst_vld",  32'(bus4.vld_o),  32'h0);
      chk("rst_src",  32'(bus4.src_o),  32'h0);
      chk("rst_busy", 32'(bus4.busy_o), 32'h0);
      chk("rst_y",    32'(y),           32'h0);
      rst = 1'b0;
      tick();

      // Sole requester 0: re-granted every burst, no bubbles
      bus4.req_i = 8'h01;
      tick();
      chk("t2_first_gnt",  32'(bus4.gnt_o),  32'h01);
      chk("t2_first_vld",  32'(bus4.vld_o),  32'h0);
      chk("t2_first_busy", 32'(bus4.busy_o), 32'h1);
      for (int t = 2; t <= 11; t++) begin
         tick();
         chk("t2_gnt", 32'(bus4.gnt_o), 32'h01);
         chk("t2_vld", 32'(bus4.vld_o), 32'h1);
         chk("t2_src", 32'(bus4.src_o), 32'h0);
         chk("t2_y",   32'(y),          32'(din[0]));
      end

      // Reset mid-burst: outputs clear immediately
      rst = 1'b1;
      #1;
      chk("mid_rst_gnt",  32'(bus4.gnt_o),  32'h0);
      chk("mid_rst_vld",  32'(bus4.vld_o),  32'h0);
      chk("mid_rst_busy", 32'(bus4.busy_o), 32'h0);
      chk("mid_rst_sel",  32'(bus4.sel_o),  32'h0);
      bus4.req_i = 8'h00;
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_gnt",  32'(bus4.gnt_o),  32'h0);
      chk("post_rst_busy", 32'(bus4.busy_o), 32'h0);
      chk("post_rst_vld",  32'(bus4.vld_o),  32'h0);

      // Requesters 0 and 7, pointer 0: 0,0,0,0,7,7,7,7,0,...
      bus4.req_i = 8'h81;
      prev_sel = 0;
      for (int t = 1; t <= 12; t++) begin
         tick();
         exp_sel = (((t - 1) / 4) % 2 == 0) ? 0 : 7;
         exp_gnt = 8'd1 << exp_sel;
         chk("t3_sel", 32'(bus4.sel_o), 32'(exp_sel));
         chk("t3_gnt", 32'(bus4.gnt_o), 32'(exp_gnt));
         if (t >= 2) begin
            chk("t3_vld", 32'(bus4.vld_o), 32'h1);
            chk("t3_src", 32'(bus4.src_o), 32'(prev_sel));
            chk("t3_y",   32'(y),          32'(din[prev_sel]));
         end else begin
            chk("t3_vld0", 32'(bus4.vld_o), 32'h0);
         end
         prev_sel = exp_sel;
      end
      bus4.req_i = 8'h00;
      tick();
      chk("t3_idle_gnt",  32'(bus4.gnt_o),  32'h0);
      chk("t3_idle_busy", 32'(bus4.busy_o), 32'h0);
      chk("t3_idle_vld",  32'(bus4.vld_o),  32'h0);
      chk("t3_idle_sel",  32'(bus4.sel_o),  32'h0);

      // Owner 2 drops after 2 beats, requester 5 takes over (pointer now 1)
      bus4.req_i = 8'h24;
      tick();
      chk("t5_gnt2", 32'(bus4.gnt_o), 32'h04);
      chk("t5_sel2", 32'(bus4.sel_o), 32'h2);
      tick();
      chk("t5_b1_vld", 32'(bus4.vld_o), 32'h1);
      chk("t5_b1_src", 32'(bus4.src_o), 32'h2);
      tick();
      chk("t5_b2_vld", 32'(bus4.vld_o), 32'h1);
      chk("t5_b2_y",   32'(y),          32'(din[2]));
      bus4.req_i = 8'h20;
      tick();
      chk("t5_gnt5",     32'(bus4.gnt_o), 32'h20);
      chk("t5_sel5",     32'(bus4.sel_o), 32'h5);
      chk("t5_drop_vld", 32'(bus4.vld_o), 32'h0);
      for (int t = 0; t < 3; t++) begin
         tick();
         chk("t5_f_vld", 32'(bus4.vld_o), 32'h1);
         chk("t5_f_src", 32'(bus4.src_o), 32'h5);
         chk("t5_f_y",   32'(y),          32'(din[5]));
         chk("t5_f_gnt", 32'(bus4.gnt_o), 32'h20);
      end
      bus4.req_i = 8'h00;
      tick();
      chk("t5_idle_gnt", 32'(bus4.gnt_o), 32'h0);
      chk("t5_idle_sel", 32'(bus4.sel_o), 32'h5);

      // Mask clears during owner-3 burst (pointer now 6)
      bus4.req_i = 8'h18;
      tick();
      chk("t6_gnt3", 32'(bus4.gnt_o), 32'h08);
      chk("t6_sel3", 32'(bus4.sel_o), 32'h3);
      tick();
      chk("t6_b_vld", 32'(bus4.vld_o), 32'h1);
      chk("t6_b_src", 32'(bus4.src_o), 32'h3);
      chk("t6_b_y",   32'(y),          32'(din[3]));
      bus4.mask_i = 8'hF7;
      tick();
      chk("t6_gnt4",     32'(bus4.gnt_o), 32'h10);
      chk("t6_sel4",     32'(bus4.sel_o), 32'h4);
      chk("t6_mask_vld", 32'(bus4.vld_o), 32'h0);
      tick();
      chk("t6_4_vld", 32'(bus4.vld_o), 32'h1);
      chk("t6_4_src", 32'(bus4.src_o), 32'h4);
      chk("t6_4_y",   32'(y),          32'(din[4]));
      bus4.mask_i = 8'hFF;
      bus4.req_i  = 8'h00;
      tick();
      chk("t6_idle_busy", 32'(bus4.busy_o), 32'h0);
      chk("t6_idle_vld",  32'(bus4.vld_o),  32'h0);

      // BurstLen=1, all requesting, only 0..3 enabled
      bus1.req_i  = 8'hFF;
      bus1.mask_i = 8'h0F;
      for (int t = 1; t <= 9; t++) begin
         tick();
         exp_sel = (t - 1) % 4;
         exp_gnt = 8'd1 << exp_sel;
         chk("t4_sel", 32'(bus1.sel_o), 32'(exp_sel));
         chk("t4_gnt", 32'(bus1.gnt_o), 32'(exp_gnt));
         if (t >= 2) begin
            chk("t4_vld", 32'(bus1.vld_o), 32'h1);
            chk("t4_src", 32'(bus1.src_o), 32'((t - 2) % 4));
         end
      end
      bus1.req_i = 8'h00;
      tick();
      chk("t4_idle_busy", 32'(bus1.busy_o), 32'h0);
      chk("t4_idle_gnt",  32'(bus1.gnt_o),  32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
